// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage for mips_core: walks a PC through a synchronous ROM and hands words to the
// core through a 2-entry queue. Optional R-type-only filtering is enabled with MIPS_FETCH_RTYPE_ONLY_EN.
module mips_fetch_unit #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          MAX_INSTR = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       pc_out,
    output logic              halted,
    output logic [15:0]       instr_count,
`ifdef MIPS_FETCH_RTYPE_ONLY_EN
    output logic [15:0]       skip_count,
`endif
    output logic [1:0]        dbg_state_o
);

    // Handshake: a word moves to the core on a cycle where instr_valid & instr_ready are both high;
    // instr_valid comes only from queue occupancy and instr_out/pc_out hold until that transfer.

    localparam int PC_W = ADDR_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            in_flight_q, in_flight_d;
    logic [PC_W-1:0] fl_pc_q, fl_pc_d;
    logic [31:0]     qd_q [2];
    logic [PC_W-1:0] qp_q [2];
    logic            hd_q, hd_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     kept_q, kept_d;
    logic [15:0]     icnt_q, icnt_d;
    logic [15:0]     skip_q, skip_d;

    logic            restart;
    logic            ret_halt;
    logic            ret_skip;
    logic            enq;
    logic            deq;
    logic            max_hit;
    logic            issue;
    logic            wr_idx;
    logic [2:0]      slots_used;

    assign restart  = start && (state_q == S_IDLE || state_q == S_HALT);
    assign ret_halt = in_flight_q && (imem_rdata == HALT_WORD);
`ifdef MIPS_FETCH_RTYPE_ONLY_EN
    assign ret_skip = in_flight_q && !ret_halt && (imem_rdata[31:26] != 6'b000000);
`else
    assign ret_skip = 1'b0;
`endif
    assign enq      = in_flight_q && !ret_halt && !ret_skip;
    assign deq      = instr_valid && instr_ready;
    assign max_hit  = (MAX_INSTR != 0) && (kept_q == 32'(MAX_INSTR));
    assign wr_idx   = hd_q ^ cnt_q[0];

    // A dequeue in the same cycle frees a slot, which keeps one word per cycle flowing.
    assign slots_used = {1'b0, cnt_q} + {2'b00, in_flight_q} - {2'b00, deq};
    assign issue      = (state_q == S_RUN) && !ret_halt && !max_hit && (slots_used < 3'd2);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (ret_halt || (max_hit && !in_flight_q)) state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == 2'd0 && !in_flight_q) state_d = S_HALT;
            S_HALT:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        in_flight_d = issue;
        fl_pc_d     = fl_pc_q;
        hd_d        = hd_q ^ deq;
        cnt_d       = cnt_q + {1'b0, enq} - {1'b0, deq};
        kept_d      = kept_q;
        icnt_d      = icnt_q;
        skip_d      = skip_q;
        if (issue) begin
            pc_d    = pc_q + PC_W'(4);
            fl_pc_d = pc_q;
        end
        // Skipped words give their MAX_INSTR slot back so the run still delivers MAX_INSTR words.
        if (MAX_INSTR != 0) begin
            kept_d = kept_q + 32'(issue) - 32'(ret_skip);
        end
        if (deq && icnt_q != 16'hFFFF) begin
            icnt_d = icnt_q + 16'd1;
        end
        if (ret_skip && skip_q != 16'hFFFF) begin
            skip_d = skip_q + 16'd1;
        end
        if (restart) begin
            pc_d        = '0;
            in_flight_d = 1'b0;
            hd_d        = 1'b0;
            cnt_d       = 2'd0;
            kept_d      = '0;
            icnt_d      = '0;
            skip_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            in_flight_q <= 1'b0;
            fl_pc_q     <= '0;
            hd_q        <= 1'b0;
            cnt_q       <= 2'd0;
            kept_q      <= '0;
            icnt_q      <= '0;
            skip_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            in_flight_q <= in_flight_d;
            fl_pc_q     <= fl_pc_d;
            hd_q        <= hd_d;
            cnt_q       <= cnt_d;
            kept_q      <= kept_d;
            icnt_q      <= icnt_d;
            skip_q      <= skip_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qd_q[0] <= '0;
            qd_q[1] <= '0;
            qp_q[0] <= '0;
            qp_q[1] <= '0;
        end else if (enq && !restart) begin
            qd_q[wr_idx] <= imem_rdata;
            qp_q[wr_idx] <= fl_pc_q;
        end
    end

    assign imem_rd_en  = issue;
    assign imem_addr   = pc_q[PC_W-1:2];
    assign instr_valid = (cnt_q != 2'd0);
    assign instr_out   = qd_q[hd_q];
    assign pc_out      = 32'(qp_q[hd_q]);
    assign halted      = (state_q == S_HALT);
    assign instr_count = icnt_q;
    assign dbg_state_o = state_q;
`ifdef MIPS_FETCH_RTYPE_ONLY_EN
    assign skip_count  = skip_q;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: one default-parameter instance and one small-ROM instance
// (ADDR_W=2, MAX_INSTR=5), each with its own ROM model and expected-word scoreboard.
module tb_mips_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        ready_a = 1'b0, ready_b = 1'b0;

    logic        a_rd_en, a_valid, a_halted;
    logic [5:0]  a_addr;
    logic [31:0] a_rdata = '0, a_instr, a_pc;
    logic [15:0] a_count;
    logic [1:0]  a_state;
    logic        b_rd_en, b_valid, b_halted;
    logic [1:0]  b_addr;
    logic [31:0] b_rdata = '0, b_instr, b_pc;
    logic [15:0] b_count;
    logic [1:0]  b_state;
`ifdef MIPS_FETCH_RTYPE_ONLY_EN
    logic [15:0] a_skip, b_skip;
`endif

    mips_fetch_unit u_dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .imem_rd_en(a_rd_en), .imem_addr(a_addr), .imem_rdata(a_rdata),
        .instr_out(a_instr), .instr_valid(a_valid), .instr_ready(ready_a),
        .pc_out(a_pc), .halted(a_halted), .instr_count(a_count),
`ifdef MIPS_FETCH_RTYPE_ONLY_EN
        .skip_count(a_skip),
`endif
        .dbg_state_o(a_state)
    );

    mips_fetch_unit #(.ADDR_W(2), .MAX_INSTR(5)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .imem_rd_en(b_rd_en), .imem_addr(b_addr), .imem_rdata(b_rdata),
        .instr_out(b_instr), .instr_valid(b_valid), .instr_ready(ready_b),
        .pc_out(b_pc), .halted(b_halted), .instr_count(b_count),
`ifdef MIPS_FETCH_RTYPE_ONLY_EN
        .skip_count(b_skip),
`endif
        .dbg_state_o(b_state)
    );

    logic [31:0] rom_a [64];
    logic [31:0] rom_b [4];
    always @(posedge clk) if (a_rd_en) a_rdata <= rom_a[a_addr];
    always @(posedge clk) if (b_rd_en) b_rdata <= rom_b[b_addr];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_a_q[$], exp_apc_q[$], exp_b_q[$], exp_bpc_q[$];
    logic [31:0] b_addr_log[$];
    int          a_xfers, a_first, a_last, a_reads, b_xfers, b_reads;
    logic        a_hold = 1'b0;
    logic [31:0] a_hold_instr, a_hold_pc;

    always @(negedge clk) begin
        if (reset) begin
            a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                check("a_hold_valid", 32'(a_valid), 1);
                check("a_hold_instr", a_instr, a_hold_instr);
                check("a_hold_pc", a_pc, a_hold_pc);
            end
            if (a_valid && ready_a) begin
                if (exp_a_q.size() == 0) begin
                    check("a_unexpected_xfer", exp_a_q.size(), 1);
                end else begin
                    check("a_instr", a_instr, exp_a_q.pop_front());
                    check("a_pc", a_pc, exp_apc_q.pop_front());
                end
                a_xfers++;
                if (a_xfers == 1) a_first = cyc;
                a_last = cyc;
            end
            a_hold       = a_valid && !ready_a;
            a_hold_instr = a_instr;
            a_hold_pc    = a_pc;
            if (a_rd_en) a_reads++;
            if (b_valid && ready_b) begin
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected_xfer", exp_b_q.size(), 1);
                end else begin
                    check("b_instr", b_instr, exp_b_q.pop_front());
                    check("b_pc", b_pc, exp_bpc_q.pop_front());
                end
                b_xfers++;
            end
            if (b_rd_en) begin
                b_reads++;
                b_addr_log.push_back(32'(b_addr));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input logic [31:0] w, input logic [31:0] pc);
        exp_a_q.push_back(w);
        exp_apc_q.push_back(pc);
    endtask

    task automatic push_b(input logic [31:0] w, input logic [31:0] pc);
        exp_b_q.push_back(w);
        exp_bpc_q.push_back(pc);
    endtask

    task automatic pulse_start(input bit which_b);
        if (which_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_halt(input bit which_b, input string tag);
        int n = 0;
        while (!(which_b ? b_halted : a_halted) && n < 60) begin
            tick();
            n++;
        end
        check(tag, 32'(which_b ? b_halted : a_halted), 1);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 64; i++) rom_a[i] = HALT;
        rom_a[0] = 32'h0145_0820;
        rom_a[1] = 32'h0145_4021;
        rom_a[2] = 32'h0145_0822;
        for (int i = 0; i < 4; i++) rom_b[i] = 32'h0022_1820 + 32'(i);

        tick(2);
        check("rst_valid", 32'(a_valid), 0);
        check("rst_rd_en", 32'(a_rd_en), 0);
        check("rst_addr", 32'(a_addr), 0);
        check("rst_pc", a_pc, 0);
        check("rst_instr", a_instr, 0);
        check("rst_halted", 32'(a_halted), 0);
        check("rst_count", 32'(a_count), 0);
        check("rst_state", 32'(a_state), 0);
        reset = 1'b0;
        tick();

        // Three R-type words then halt, core always ready.
        push_a(32'h0145_0820, 0);
        push_a(32'h0145_4021, 4);
        push_a(32'h0145_0822, 8);
        ready_a = 1'b1;
        a_xfers = 0;
        pulse_start(1'b0);
        check("t1_rd_en", 32'(a_rd_en), 1);
        check("t1_state_run", 32'(a_state), 1);
        lat = 0;
        while (!a_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("t1_latency", 32'(lat), 2);
        wait_halt(1'b0, "t1_halt");
        check("t1_count", 32'(a_count), 3);
        check("t1_xfers", 32'(a_xfers), 3);
        check("t1_back_to_back", 32'(a_last - a_first), 2);
        check("t1_sb_empty", exp_a_q.size(), 0);

        // Core stalls: head held, no more than two reads taken.
        push_a(32'h0145_0820, 0);
        push_a(32'h0145_4021, 4);
        push_a(32'h0145_0822, 8);
        ready_a = 1'b0;
        a_reads = 0;
        pulse_start(1'b0);
        check("t2_count_clear", 32'(a_count), 0);
        tick(8);
        check("t2_reads_le2", 32'(a_reads <= 2), 1);
        check("t2_valid", 32'(a_valid), 1);
        check("t2_head", a_instr, 32'h0145_0820);
        check("t2_head_pc", a_pc, 0);
        ready_a = 1'b1;
        wait_halt(1'b0, "t2_halt");
        check("t2_count", 32'(a_count), 3);
        check("t2_sb_empty", exp_a_q.size(), 0);

        // Reset with a full queue; late ROM data must not reappear.
        ready_a = 1'b0;
        pulse_start(1'b0);
        tick(3);
        check("t5_pre_valid", 32'(a_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_valid", 32'(a_valid), 0);
        check("t5_pc", a_pc, 0);
        check("t5_state", 32'(a_state), 0);
        check("t5_rd_en", 32'(a_rd_en), 0);
        tick(3);
        check("t5_valid_late", 32'(a_valid), 0);
        check("t5_state_late", 32'(a_state), 0);
        check("t5_count", 32'(a_count), 0);

        // Non-R-type load in the stream.
        rom_a[1] = 32'h8C22_0004;
        push_a(32'h0145_0820, 0);
`ifndef MIPS_FETCH_RTYPE_ONLY_EN
        push_a(32'h8C22_0004, 4);
`endif
        push_a(32'h0145_0822, 8);
        ready_a = 1'b1;
        pulse_start(1'b0);
        wait_halt(1'b0, "t6_halt");
`ifdef MIPS_FETCH_RTYPE_ONLY_EN
        check("t6_count", 32'(a_count), 2);
        check("t6_skip", 32'(a_skip), 1);
`else
        check("t6_count", 32'(a_count), 3);
`endif
        check("t6_sb_empty", exp_a_q.size(), 0);

        // Small ROM: address wraps 3 -> 0, run stops after exactly five words.
        for (int i = 0; i < 5; i++) push_b(rom_b[i % 4], 32'((i % 4) * 4));
        ready_b = 1'b1;
        b_reads = 0;
        b_xfers = 0;
        b_addr_log.delete();
        pulse_start(1'b1);
        wait_halt(1'b1, "t3_halt");
        check("t3_reads", 32'(b_reads), 5);
        for (int i = 0; i < b_addr_log.size() && i < 5; i++) begin
            check("t3_addr", b_addr_log[i], 32'(i % 4));
        end
        check("t4_xfers", 32'(b_xfers), 5);
        check("t4_count", 32'(b_count), 5);
        check("t4_sb_empty", exp_b_q.size(), 0);

        for (int i = 0; i < 5; i++) push_b(rom_b[i % 4], 32'((i % 4) * 4));
        pulse_start(1'b1);
        check("t4_count_clear", 32'(b_count), 0);
        check("t4_halted_clear", 32'(b_halted), 0);
        wait_halt(1'b1, "t4_rerun_halt");
        check("t4_rerun_count", 32'(b_count), 5);
        check("t4_rerun_sb_empty", exp_b_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
